// File: rtl/syn_gpu_pxl_gw.sv
// Pixel gateway responder: turns (posx, posy) pixel requests into linear
// frame-buffer accesses on a request/grant memory port. Read data comes back
// to the requester in order.
module syn_gpu_pxl_gw #(
    parameter int P_X_W       = 10,
    parameter int P_Y_W       = 9,
    parameter int P_PXL_W     = 8,
    parameter int P_H_RES     = 640,
    parameter int P_V_RES     = 480,
    parameter int P_FB_ADDR_W = 19,
    parameter int P_REQ_DEPTH = 4,
    parameter int P_MAX_RD    = 4
) (
    input  logic                   clk_ir,
    input  logic                   rst_sync,
    input  logic [P_PXL_W-1:0]     pxl,
    input  logic                   pxl_wr_valid,
    input  logic                   pxl_rd_valid,
    input  logic [P_X_W-1:0]       posx,
    input  logic [P_Y_W-1:0]       posy,
    output logic                   ready,
    output logic [P_PXL_W-1:0]     rd_pxl,
    output logic                   rd_rdy,
    output logic                   mem_req,
    output logic                   mem_wr,
    output logic [P_FB_ADDR_W-1:0] mem_addr,
    output logic [P_PXL_W-1:0]     mem_wdata,
    input  logic                   mem_gnt,
    input  logic [P_PXL_W-1:0]     mem_rdata,
    input  logic                   mem_rvalid,
    output logic [15:0]            oob_cnt,
    output logic                   proto_err
);
    localparam int AW  = $clog2(P_REQ_DEPTH);
    localparam int TW  = $clog2(P_MAX_RD);
    localparam int CW  = AW + 1;
    localparam int TCW = TW + 1;
    localparam logic [P_FB_ADDR_W-1:0] H_RES_A = P_FB_ADDR_W'(P_H_RES);

    typedef struct packed {
        logic                   wr;
        logic [P_FB_ADDR_W-1:0] addr;
        logic [P_PXL_W-1:0]     data;
        logic                   oob;
    } req_t;

    // Request FIFO and return-tag queue (tag = "this read was out of range")
    req_t           req_mem [P_REQ_DEPTH];
    logic [AW-1:0]  req_wp, req_rp;
    logic [CW-1:0]  req_cnt, rd_in_fifo;
    logic           tag_mem [P_MAX_RD];
    logic [TW-1:0]  tag_wp, tag_rp;
    logic [TCW-1:0] tag_cnt;

    req_t           head, new_req;
    logic           head_vld, acc, pop, tag_push;
    logic           tag_head, tag_vld, tag_pop, stray;
    logic [CW-1:0]  req_cnt_n, rd_fifo_n;
    logic [TCW-1:0] tag_cnt_n;
    logic           ready_n;

    assign head     = req_mem[req_rp];
    assign tag_head = tag_mem[tag_rp];

    // Accept/pop decisions, next-state occupancy for the registered ready
    always_comb begin
        acc          = (pxl_wr_valid | pxl_rd_valid) & ready;
        new_req.wr   = pxl_wr_valid;  // write wins when both are raised
        new_req.addr = P_FB_ADDR_W'(posy) * H_RES_A + P_FB_ADDR_W'(posx);
        new_req.data = pxl;
        new_req.oob  = (int'(posx) >= P_H_RES) | (int'(posy) >= P_V_RES);

        head_vld = (req_cnt != '0);
        pop      = head_vld & (head.oob | mem_gnt);
        tag_push = pop & ~head.wr;

        tag_vld  = (tag_cnt != '0);
        // oob tags drain immediately; real reads wait for memory data
        tag_pop  = tag_vld & (tag_head | mem_rvalid);
        stray    = mem_rvalid & (~tag_vld | tag_head);

        req_cnt_n = req_cnt + CW'(acc) - CW'(pop);
        rd_fifo_n = rd_in_fifo + CW'(acc & ~pxl_wr_valid) - CW'(tag_push);
        tag_cnt_n = tag_cnt + TCW'(tag_push) - TCW'(tag_pop);
        ready_n   = (int'(req_cnt_n) < P_REQ_DEPTH) &&
                    (int'(tag_cnt_n) + int'(rd_fifo_n) < P_MAX_RD);
    end

    // Memory port is driven straight from the FIFO head; oob heads never request
    always_comb begin
        mem_req   = head_vld & ~head.oob;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_wr    = head.wr;
            mem_addr  = head.addr;
            mem_wdata = head.data;
        end
    end

    // Queue storage; contents only matter where the counts say they are valid
    always_ff @(posedge clk_ir) begin
        if (acc)      req_mem[req_wp] <= new_req;
        if (tag_push) tag_mem[tag_wp] <= head.oob;
    end

    // Pointers, counts, return path and status
    always_ff @(posedge clk_ir) begin
        if (rst_sync) begin
            req_wp     <= '0;
            req_rp     <= '0;
            req_cnt    <= '0;
            rd_in_fifo <= '0;
            tag_wp     <= '0;
            tag_rp     <= '0;
            tag_cnt    <= '0;
            ready      <= 1'b0;
            rd_rdy     <= 1'b0;
            rd_pxl     <= '0;
            oob_cnt    <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (acc)      req_wp <= req_wp + 1'b1;
            if (pop)      req_rp <= req_rp + 1'b1;
            if (tag_push) tag_wp <= tag_wp + 1'b1;
            if (tag_pop)  tag_rp <= tag_rp + 1'b1;
            req_cnt    <= req_cnt_n;
            rd_in_fifo <= rd_fifo_n;
            tag_cnt    <= tag_cnt_n;
            ready      <= ready_n;

            rd_rdy <= tag_pop;
            if (tag_pop) rd_pxl <= tag_head ? '0 : mem_rdata;

            if (pop & head.oob) oob_cnt <= oob_cnt + 16'd1;
            if ((acc & pxl_wr_valid & pxl_rd_valid) | stray) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_syn_gpu_pxl_gw.sv
// Directed bench for the pixel gateway: drives on negedge, samples on negedge.
module tb_syn_gpu_pxl_gw;
    logic        clk_ir = 1'b0;
    logic        rst_sync;
    logic [7:0]  pxl;
    logic        pxl_wr_valid, pxl_rd_valid;
    logic [9:0]  posx;
    logic [8:0]  posy;
    logic        ready;
    logic [7:0]  rd_pxl;
    logic        rd_rdy;
    logic        mem_req, mem_wr;
    logic [18:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [15:0] oob_cnt;
    logic        proto_err;

    int n_chk  = 0;
    int n_fail = 0;

    syn_gpu_pxl_gw dut (
        .clk_ir(clk_ir), .rst_sync(rst_sync), .pxl(pxl),
        .pxl_wr_valid(pxl_wr_valid), .pxl_rd_valid(pxl_rd_valid),
        .posx(posx), .posy(posy), .ready(ready), .rd_pxl(rd_pxl),
        .rd_rdy(rd_rdy), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .oob_cnt(oob_cnt),
        .proto_err(proto_err)
    );

    always #5 clk_ir = ~clk_ir;

    task automatic tick();
        @(posedge clk_ir);
        @(negedge clk_ir);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input int x, input int y, input logic [7:0] d);
        pxl_wr_valid = wr;
        pxl_rd_valid = rd;
        posx = 10'(x);
        posy = 9'(y);
        pxl  = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 8'h00);
    endtask

    initial begin
        rst_sync = 1'b1; mem_gnt = 1'b0; mem_rdata = 8'h00; mem_rvalid = 1'b0;
        idle();
        tick(); tick();
        // reset state
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rd_rdy", 32'(rd_rdy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_oob_cnt", 32'(oob_cnt), 32'd0);
        chk("rst_proto", 32'(proto_err), 32'd0);
        rst_sync = 1'b0;
        tick();
        chk("ready_after_rst", 32'(ready), 32'd1);

        // single write, grant tied high
        mem_gnt = 1'b1;
        drive(1'b1, 1'b0, 5, 2, 8'hA5);
        tick(); idle();
        chk("wr_mem_req", 32'(mem_req), 32'd1);
        chk("wr_mem_wr", 32'(mem_wr), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'd1285);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
        tick();
        chk("wr_done_req", 32'(mem_req), 32'd0);
        chk("wr_no_rd_rdy", 32'(rd_rdy), 32'd0);

        // corner read, 3-cycle memory latency
        drive(1'b0, 1'b1, 639, 479, 8'h00);
        tick(); idle();
        chk("rd_mem_req", 32'(mem_req), 32'd1);
        chk("rd_mem_wr", 32'(mem_wr), 32'd0);
        chk("rd_mem_addr", 32'(mem_addr), 32'd307199);
        tick(); tick();
        chk("rd_wait_rdy", 32'(rd_rdy), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 8'h3C;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 8'h00;
        chk("rd_rdy_pulse", 32'(rd_rdy), 32'd1);
        chk("rd_pxl", 32'(rd_pxl), 32'h3C);
        tick();
        chk("rd_rdy_once", 32'(rd_rdy), 32'd0);
        chk("rd_pxl_hold", 32'(rd_pxl), 32'h3C);

        // FIFO fill with grant held low
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("fill_ready", 32'(ready), 32'd1);
            drive(1'b1, 1'b0, 10 + i, 0, 8'(i));
            tick();
        end
        drive(1'b1, 1'b0, 14, 0, 8'h04);
        chk("full_ready", 32'(ready), 32'd0);
        chk("full_head", 32'(mem_addr), 32'd10);
        tick();
        chk("full_hold_ready", 32'(ready), 32'd0);
        chk("full_hold_req", 32'(mem_req), 32'd1);
        chk("full_hold_addr", 32'(mem_addr), 32'd10);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("after_gnt_ready", 32'(ready), 32'd1);
        chk("after_gnt_addr", 32'(mem_addr), 32'd11);
        tick(); idle();
        chk("fifth_acc_ready", 32'(ready), 32'd0);
        mem_gnt = 1'b1;
        for (int j = 11; j <= 14; j++) begin
            chk("drain_addr", 32'(mem_addr), 32'(j));
            chk("drain_wr", 32'(mem_wr), 32'd1);
            tick();
        end
        chk("drain_empty", 32'(mem_req), 32'd0);

        // in-order return with an out-of-range read in the middle
        drive(1'b0, 1'b1, 1, 0, 8'h00);
        tick();
        chk("r1_req", 32'(mem_req), 32'd1);
        chk("r1_addr", 32'(mem_addr), 32'd1);
        drive(1'b0, 1'b1, 700, 0, 8'h00);
        tick();
        chk("oob_no_req", 32'(mem_req), 32'd0);
        drive(1'b0, 1'b1, 2, 0, 8'h00);
        tick(); idle();
        chk("r2_req", 32'(mem_req), 32'd1);
        chk("r2_addr", 32'(mem_addr), 32'd2);
        tick();
        chk("r_all_issued", 32'(mem_req), 32'd0);
        chk("oob_cnt_1", 32'(oob_cnt), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 8'h11;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 8'h00;
        chk("ret0_rdy", 32'(rd_rdy), 32'd1);
        chk("ret0_pxl", 32'(rd_pxl), 32'h11);
        tick();
        chk("ret1_rdy", 32'(rd_rdy), 32'd1);
        chk("ret1_pxl", 32'(rd_pxl), 32'h00);
        tick();
        chk("ret_gap", 32'(rd_rdy), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 8'h22;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 8'h00;
        chk("ret2_rdy", 32'(rd_rdy), 32'd1);
        chk("ret2_pxl", 32'(rd_pxl), 32'h22);
        chk("ret_no_err", 32'(proto_err), 32'd0);

        // write and read raised together
        drive(1'b1, 1'b1, 0, 0, 8'h5A);
        tick(); idle();
        chk("both_req", 32'(mem_req), 32'd1);
        chk("both_wr", 32'(mem_wr), 32'd1);
        chk("both_addr", 32'(mem_addr), 32'd0);
        chk("both_wdata", 32'(mem_wdata), 32'h5A);
        chk("both_err", 32'(proto_err), 32'd1);
        tick();
        chk("both_no_read", 32'(mem_req), 32'd0);
        tick();
        chk("both_err_sticky", 32'(proto_err), 32'd1);
        chk("both_no_rdy", 32'(rd_rdy), 32'd0);

        // reset with two reads outstanding, then a stray return
        drive(1'b0, 1'b1, 3, 0, 8'h00);
        tick();
        drive(1'b0, 1'b1, 4, 0, 8'h00);
        tick(); idle();
        tick();
        rst_sync = 1'b1;
        tick();
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_err", 32'(proto_err), 32'd0);
        chk("mid_rst_pxl", 32'(rd_pxl), 32'd0);
        chk("mid_rst_oob", 32'(oob_cnt), 32'd0);
        rst_sync = 1'b0;
        tick();
        chk("post_rst_ready", 32'(ready), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 8'h77;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 8'h00;
        chk("stray_no_rdy", 32'(rd_rdy), 32'd0);
        chk("stray_err", 32'(proto_err), 32'd1);

        // out-of-range write on the y boundary
        drive(1'b1, 1'b0, 0, 480, 8'h99);
        tick(); idle();
        chk("oob_wr_no_req", 32'(mem_req), 32'd0);
        tick();
        chk("oob_wr_cnt", 32'(oob_cnt), 32'd1);
        chk("oob_wr_no_rdy", 32'(rd_rdy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
